// File: rtl/y86_pkg.sv
// y86_pkg: shared Y86-64 instruction codes, status codes, sequencer states and decode helpers.
// Contents: icode localparams, stat codes, state_t enumeration,
//           needs_mem / mem_is_write / writes_e / writes_m classifiers.
package y86_pkg;
    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [2:0] SAOK = 3'd1;
    localparam logic [2:0] SHLT = 3'd2;
    localparam logic [2:0] SADR = 3'd3;
    localparam logic [2:0] SINS = 3'd4;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY,
        S_WB_E, S_WB_M, S_PCUPD, S_HALT, S_ERROR
    } state_t;

    function automatic logic needs_mem(input logic [3:0] ic);
        return ic inside {IRMMOVQ, IMRMOVQ, ICALL, IRET, IPUSHQ, IPOPQ};
    endfunction

    function automatic logic mem_is_write(input logic [3:0] ic);
        return ic inside {IRMMOVQ, ICALL, IPUSHQ};
    endfunction

    // rrmovq shares icode 2 with cmovXX, so its valE write is gated by cnd
    function automatic logic writes_e(input logic [3:0] ic, input logic c);
        return (ic inside {IIRMOVQ, IOPQ, ICALL, IRET, IPUSHQ, IPOPQ}) || (ic == IRRMOVQ && c);
    endfunction

    function automatic logic writes_m(input logic [3:0] ic);
        return ic inside {IMRMOVQ, IPOPQ};
    endfunction
endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: loadable down-counter whose expired flag marks the last permitted wait cycle.
// Ports: clk, reset (sync, active-high), load (reload with load_val),
//        en (decrement while nonzero), load_val, expired (count == 0).
module mem_wait_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         expired
);
    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) count <= '0;
        else if (load) count <= load_val;
        else if (en && count != '0) count <= count - W'(1);
    end

    assign expired = (count == '0);
endmodule

// File: rtl/seq_stage_controller.sv
// seq_stage_controller: multicycle Y86-64 SEQ sequencer stepping one stage per cycle.
// Inputs : clk, reset (sync, active-high), start, icode, instr_valid, imem_error,
//          cnd, mem_ack, dmem_error.
// Outputs: fetch_en, decode_en, execute_en, mem_req, mem_write, cc_we, wb_e_en,
//          wb_m_en, pc_we (stage strobes), stat, busy, instr_count.
module seq_stage_controller
    import y86_pkg::*;
#(
    parameter int MEM_TIMEOUT = 8,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       icode,
    input  logic             instr_valid,
    input  logic             imem_error,
    input  logic             cnd,
    input  logic             mem_ack,
    input  logic             dmem_error,
    output logic             fetch_en,
    output logic             decode_en,
    output logic             execute_en,
    output logic             mem_req,
    output logic             mem_write,
    output logic             cc_we,
    output logic             wb_e_en,
    output logic             wb_m_en,
    output logic             pc_we,
    output logic [2:0]       stat,
    output logic             busy,
    output logic [CNT_W-1:0] instr_count
);
    localparam int TW = $clog2(MEM_TIMEOUT + 1);

    state_t     state_q, state_d;
    logic [3:0] icode_q;
    logic [2:0] stat_d;
    logic       mem_expired;

    // Loaded during EXECUTE so it holds MEM_TIMEOUT-1 on the first MEMORY cycle;
    // expiry then coincides with the MEM_TIMEOUT-th wait cycle.
    mem_wait_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (state_q == S_EXECUTE),
        .en       (state_q == S_MEMORY),
        .load_val (TW'(MEM_TIMEOUT - 1)),
        .expired  (mem_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            stat        <= SAOK;
            icode_q     <= IHALT;
            instr_count <= '0;
        end else begin
            state_q <= state_d;
            stat    <= stat_d;
            if (state_q == S_FETCH) icode_q <= icode;
            if (pc_we) instr_count <= instr_count + CNT_W'(1);
        end
    end

    always_comb begin
        state_d    = state_q;
        stat_d     = stat;
        fetch_en   = 1'b0;
        decode_en  = 1'b0;
        execute_en = 1'b0;
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        cc_we      = 1'b0;
        wb_e_en    = 1'b0;
        wb_m_en    = 1'b0;
        pc_we      = 1'b0;
        case (state_q)
            S_IDLE: state_d = start ? S_FETCH : S_IDLE;
            S_FETCH: begin
                fetch_en = 1'b1;
                if (imem_error) begin
                    state_d = S_ERROR;
                    stat_d  = SADR;
                end else if (!instr_valid) begin
                    state_d = S_ERROR;
                    stat_d  = SINS;
                end else if (icode == IHALT) begin
                    state_d = S_HALT;
                    stat_d  = SHLT;
                end else begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                decode_en = 1'b1;
                state_d   = S_EXECUTE;
            end
            S_EXECUTE: begin
                execute_en = 1'b1;
                cc_we      = (icode_q == IOPQ);
                state_d    = needs_mem(icode_q) ? S_MEMORY : S_WB_E;
            end
            S_MEMORY: begin
                mem_req   = 1'b1;
                mem_write = mem_is_write(icode_q);
                // an ack arriving on the final wait cycle still wins over the timeout
                if (mem_ack) begin
                    state_d = dmem_error ? S_ERROR : S_WB_E;
                    stat_d  = dmem_error ? SADR : stat;
                end else if (mem_expired) begin
                    state_d = S_ERROR;
                    stat_d  = SADR;
                end
            end
            S_WB_E: begin
                wb_e_en = writes_e(icode_q, cnd);
                state_d = writes_m(icode_q) ? S_WB_M : S_PCUPD;
            end
            S_WB_M: begin
                wb_m_en = 1'b1;
                state_d = S_PCUPD;
            end
            S_PCUPD: begin
                pc_we   = 1'b1;
                state_d = S_FETCH;
            end
            default: state_d = state_q;
        endcase
    end

    assign busy = !(state_q inside {S_IDLE, S_HALT, S_ERROR});
endmodule

// File: tb/tb_seq_stage_controller.sv
// tb_seq_stage_controller: self-checking bench comparing per-cycle strobe vectors against an
// instruction-level model of the stage sequence.
module tb_seq_stage_controller;
    localparam int TO = 8;
    localparam logic [9:0] V_B  = 10'h200, V_F  = 10'h100, V_D  = 10'h080, V_E  = 10'h040;
    localparam logic [9:0] V_M  = 10'h020, V_MW = 10'h010, V_CC = 10'h008, V_WE = 10'h004;
    localparam logic [9:0] V_WM = 10'h002, V_PC = 10'h001;

    logic        clk = 1'b0;
    logic        reset, start, instr_valid, imem_error, cnd, mem_ack, dmem_error;
    logic [3:0]  icode;
    logic        fetch_en, decode_en, execute_en, mem_req, mem_write, cc_we;
    logic        wb_e_en, wb_m_en, pc_we, busy;
    logic [2:0]  stat;
    logic [31:0] instr_count;
    logic [9:0]  obs_vec;

    int          checks = 0, passes = 0;
    logic [9:0]  exp_q[$], obs_q[$];
    int          model_count;
    logic [2:0]  model_stat;

    seq_stage_controller #(.MEM_TIMEOUT(TO), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .start(start), .icode(icode),
        .instr_valid(instr_valid), .imem_error(imem_error), .cnd(cnd),
        .mem_ack(mem_ack), .dmem_error(dmem_error), .fetch_en(fetch_en),
        .decode_en(decode_en), .execute_en(execute_en), .mem_req(mem_req),
        .mem_write(mem_write), .cc_we(cc_we), .wb_e_en(wb_e_en), .wb_m_en(wb_m_en),
        .pc_we(pc_we), .stat(stat), .busy(busy), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    assign obs_vec = {busy, fetch_en, decode_en, execute_en, mem_req, mem_write,
                      cc_we, wb_e_en, wb_m_en, pc_we};

    // Expected per-cycle strobe vectors for one instruction, starting at its FETCH cycle.
    task automatic model_instr(input logic [3:0] ic, input bit c, input int ack_at,
                               input bit derr, input bit valid, input bit ierr);
        int n;
        bit timeout;
        exp_q.delete();
        exp_q.push_back(V_B | V_F);
        if (ierr || !valid || ic == 4'd0) begin
            model_stat = ierr ? 3'd3 : (!valid ? 3'd4 : 3'd2);
            repeat (3) exp_q.push_back(10'h000);
            return;
        end
        exp_q.push_back(V_B | V_D);
        exp_q.push_back(V_B | V_E | ((ic == 4'd6) ? V_CC : 10'h000));
        if (ic inside {4, 5, 8, 9, 10, 11}) begin
            timeout = (ack_at < 0 || ack_at >= TO);
            n = timeout ? TO : ack_at + 1;
            repeat (n) exp_q.push_back(V_B | V_M | ((ic inside {4, 8, 10}) ? V_MW : 10'h000));
            if (timeout || derr) begin
                model_stat = 3'd3;
                repeat (3) exp_q.push_back(10'h000);
                return;
            end
        end
        exp_q.push_back(V_B | (((ic inside {3, 6, 8, 9, 10, 11}) || (ic == 4'd2 && c)) ? V_WE : 10'h000));
        if (ic inside {5, 11}) exp_q.push_back(V_B | V_WM);
        exp_q.push_back(V_B | V_PC);
        model_count++;
    endtask

    // Drives one instruction from its FETCH cycle; icode is scrambled after FETCH
    // to show the latched copy is used.
    task automatic run_instr(input logic [3:0] ic, input bit c, input int ack_at,
                             input bit derr, input bit valid, input bit ierr, input int n);
        obs_q.delete();
        for (int k = 0; k < n; k++) begin
            icode       = (k == 0) ? ic : 4'($urandom);
            instr_valid = (k == 0) ? valid : 1'($urandom);
            imem_error  = (k == 0) ? ierr : 1'($urandom);
            cnd         = c;
            mem_ack     = (ack_at >= 0 && k == 3 + ack_at);
            dmem_error  = mem_ack ? derr : 1'($urandom);
            start       = 1'($urandom);
            #1 obs_q.push_back(obs_vec);
            @(negedge clk);
        end
        mem_ack = 1'b0;
    endtask

    task automatic do_reset;
        reset = 1'b1; start = 1'b0; mem_ack = 1'b0; dmem_error = 1'b0; icode = 4'd0;
        instr_valid = 1'b1; imem_error = 1'b0; cnd = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_count = 0;
        model_stat = 3'd1;
    endtask

    task automatic begin_run;
        start = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs_vec !== 10'h000 || stat !== 3'd1 || instr_count !== 32'd0)
                $display("FAIL reset_idle cyc%0d: strobes=%b stat=%0d cnt=%0d want 0/1/0", i, obs_vec, stat, instr_count);
            else passes++;
            @(negedge clk);
        end
    endtask

    task automatic test_irmovq;
        begin_run();
        model_instr(4'd3, 1'b0, -1, 1'b0, 1'b1, 1'b0);
        run_instr(4'd3, 1'b0, -1, 1'b0, 1'b1, 1'b0, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) $display("FAIL irmovq cyc%0d: got %b want %b", i, obs_q[i], exp_q[i]);
            else passes++;
        end
        checks++;
        if (instr_count !== 32'(model_count)) $display("FAIL irmovq_count: got %0d want %0d", instr_count, model_count);
        else passes++;
    endtask

    task automatic test_popq;
        model_instr(4'd11, 1'b0, 1, 1'b0, 1'b1, 1'b0);
        run_instr(4'd11, 1'b0, 1, 1'b0, 1'b1, 1'b0, exp_q.size());
        checks++;
        if (exp_q.size() != 8 || !fetch_en) $display("FAIL popq_latency: len=%0d fetch_en=%b want 8/1", exp_q.size(), fetch_en);
        else passes++;
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) $display("FAIL popq cyc%0d: got %b want %b", i, obs_q[i], exp_q[i]);
            else passes++;
        end
    endtask

    task automatic test_cmov;
        for (int c = 0; c < 2; c++) begin
            model_instr(4'd2, 1'(c), -1, 1'b0, 1'b1, 1'b0);
            run_instr(4'd2, 1'(c), -1, 1'b0, 1'b1, 1'b0, exp_q.size());
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) $display("FAIL cmov_cnd%0d cyc%0d: got %b want %b", c, i, obs_q[i], exp_q[i]);
                else passes++;
            end
        end
        checks++;
        if (instr_count !== 32'(model_count)) $display("FAIL cmov_count: got %0d want %0d", instr_count, model_count);
        else passes++;
    endtask

    task automatic test_timeout;
        model_instr(4'd4, 1'b0, -1, 1'b0, 1'b1, 1'b0);
        run_instr(4'd4, 1'b0, -1, 1'b0, 1'b1, 1'b0, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) $display("FAIL timeout cyc%0d: got %b want %b", i, obs_q[i], exp_q[i]);
            else passes++;
        end
        checks++;
        if (stat !== model_stat || instr_count !== 32'(model_count))
            $display("FAIL timeout_stat: stat=%0d cnt=%0d want %0d/%0d", stat, instr_count, model_stat, model_count);
        else passes++;
    endtask

    task automatic test_dmem_error;
        do_reset();
        begin_run();
        model_instr(4'd5, 1'b0, 2, 1'b1, 1'b1, 1'b0);
        run_instr(4'd5, 1'b0, 2, 1'b1, 1'b1, 1'b0, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) $display("FAIL dmem_err cyc%0d: got %b want %b", i, obs_q[i], exp_q[i]);
            else passes++;
        end
        checks++;
        if (stat !== model_stat) $display("FAIL dmem_err_stat: got %0d want %0d", stat, model_stat);
        else passes++;
    endtask

    task automatic test_fetch_errors;
        for (int t = 0; t < 2; t++) begin
            do_reset();
            begin_run();
            model_instr(4'd1, 1'b0, -1, 1'b0, 1'b0, 1'(t));
            run_instr(4'd1, 1'b0, -1, 1'b0, 1'b0, 1'(t), exp_q.size());
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) $display("FAIL fetch_err%0d cyc%0d: got %b want %b", t, i, obs_q[i], exp_q[i]);
                else passes++;
            end
            checks++;
            if (stat !== model_stat) $display("FAIL fetch_err%0d_stat: got %0d want %0d", t, stat, model_stat);
            else passes++;
        end
    endtask

    task automatic test_halt;
        do_reset();
        begin_run();
        model_instr(4'd3, 1'b0, -1, 1'b0, 1'b1, 1'b0);
        run_instr(4'd3, 1'b0, -1, 1'b0, 1'b1, 1'b0, exp_q.size());
        model_instr(4'd0, 1'b0, -1, 1'b0, 1'b1, 1'b0);
        run_instr(4'd0, 1'b0, -1, 1'b0, 1'b1, 1'b0, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) $display("FAIL halt cyc%0d: got %b want %b", i, obs_q[i], exp_q[i]);
            else passes++;
        end
        checks++;
        if (stat !== model_stat || instr_count !== 32'(model_count))
            $display("FAIL halt_stat: stat=%0d cnt=%0d want %0d/%0d", stat, instr_count, model_stat, model_count);
        else passes++;
    endtask

    task automatic test_reset_mid_mem;
        do_reset();
        begin_run();
        model_instr(4'd3, 1'b0, -1, 1'b0, 1'b1, 1'b0);
        run_instr(4'd3, 1'b0, -1, 1'b0, 1'b1, 1'b0, exp_q.size());
        model_instr(4'd10, 1'b0, -1, 1'b0, 1'b1, 1'b0);
        run_instr(4'd10, 1'b0, -1, 1'b0, 1'b1, 1'b0, 5);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) $display("FAIL pushq_pre_reset cyc%0d: got %b want %b", i, obs_q[i], exp_q[i]);
            else passes++;
        end
        reset = 1'b1;
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (obs_vec !== 10'h000 || stat !== 3'd1 || instr_count !== 32'd0)
            $display("FAIL reset_mid_mem: strobes=%b stat=%0d cnt=%0d want 0/1/0", obs_vec, stat, instr_count);
        else passes++;
        reset = 1'b0;
    endtask

    task automatic test_random;
        logic [3:0] ic;
        bit c;
        int ack;
        do_reset();
        begin_run();
        repeat (40) begin
            ic  = 4'($urandom_range(1, 11));
            c   = 1'($urandom);
            ack = (ic inside {4, 5, 8, 9, 10, 11}) ? int'($urandom_range(0, 3)) : -1;
            model_instr(ic, c, ack, 1'b0, 1'b1, 1'b0);
            run_instr(ic, c, ack, 1'b0, 1'b1, 1'b0, exp_q.size());
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) $display("FAIL random ic=%0h cnd=%0d cyc%0d: got %b want %b", ic, c, i, obs_q[i], exp_q[i]);
                else passes++;
            end
        end
        checks++;
        if (instr_count !== 32'(model_count) || stat !== 3'd1)
            $display("FAIL random_count: cnt=%0d stat=%0d want %0d/1", instr_count, stat, model_count);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_irmovq();
        test_popq();
        test_cmov();
        test_timeout();
        test_dmem_error();
        test_fetch_errors();
        test_halt();
        test_reset_mid_mem();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
